// File: rtl/data_memory_sized.sv
// Clocked MEM-stage data memory: byte/half/word loads and stores with a
// Req/Done handshake, configurable wait states and rejected-access reporting.
module data_memory_sized #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  input  logic [31:0] Address,
  input  logic [31:0] Write_Data,
  output logic [31:0] Read_Data,
  output logic        Busy,
  output logic        Done,
  output logic        Error
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WS_M1 = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;
  logic        uns_q, rd_q, wr_q;
  logic        accept, err;
  logic [AW-1:0] idx;
  logic [31:0] word, ld_val, wlane;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [3:0]  be;

  logic [31:0] mem [DEPTH] = '{default: '0};

  assign accept = (state == S_IDLE) && Req && (MemRead || MemWrite);
  assign Busy   = (state != S_IDLE);
  assign idx    = addr_q[AW+1:2];

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (accept) state_nx = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
      S_WAIT:   if (cnt == 4'd0) state_nx = S_ACCESS;
      S_ACCESS: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // All rejection rules act on the latched request only.
  always_comb begin
    err = (rd_q && wr_q) || (size_q == 2'b11) ||
          (size_q == 2'b01 && addr_q[0]) ||
          (size_q == 2'b10 && addr_q[1:0] != 2'b00) ||
          ((addr_q >> (AW + 2)) != 32'd0);
  end

  always_comb begin
    word   = mem[idx];
    byte_v = word[8*addr_q[1:0] +: 8];
    half_v = addr_q[1] ? word[31:16] : word[15:0];
    ld_val = 32'd0;
    case (size_q)
      2'b00:   ld_val = uns_q ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
      2'b01:   ld_val = uns_q ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
      2'b10:   ld_val = word;
      default: ld_val = 32'd0;
    endcase
  end

  // Store data is replicated across lanes so the enables alone pick the target.
  always_comb begin
    be    = 4'b0000;
    wlane = wdata_q;
    case (size_q)
      2'b00: begin be = 4'b0001 << addr_q[1:0]; wlane = {4{wdata_q[7:0]}}; end
      2'b01: begin be = addr_q[1] ? 4'b1100 : 4'b0011; wlane = {2{wdata_q[15:0]}}; end
      2'b10: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      Read_Data <= 32'd0;
      Done      <= 1'b0;
      Error     <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
    end else begin
      state <= state_nx;
      Done  <= 1'b0;
      Error <= 1'b0;
      if (accept) begin
        addr_q  <= Address;
        wdata_q <= Write_Data;
        size_q  <= Size;
        uns_q   <= Unsigned;
        rd_q    <= MemRead;
        wr_q    <= MemWrite;
        cnt     <= WS_M1;
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (state == S_ACCESS) begin
        Done      <= 1'b1;
        Error     <= err;
        Read_Data <= (err || wr_q) ? 32'd0 : ld_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && state == S_ACCESS && wr_q && !err) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wlane[8*b +: 8];
    end
  end
endmodule
